// File: rtl/rhd_spi_slave_gen2.sv
// RHD2000-family SPI slave emulator: command decoder, 18-entry register file and the chip's
// two-word result pipeline. Define RHD_SLAVE_ROM_EN to include the read-only ID registers 40-63.
module rhd_spi_slave_gen2 #(
    parameter int unsigned STARTING_SEED = 0,
    parameter int unsigned NUM_CHANNELS  = 64,
    parameter int unsigned CHIP_ID       = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic [5:0]  channel_out,
    output logic        word_done,
    output logic        cmd_error,
    output logic [15:0] frame_cnt
);

    localparam logic [6:0]  NumCh  = 7'(NUM_CHANNELS);
    localparam logic [5:0]  LastCh = 6'(NUM_CHANNELS - 1);
    localparam logic [15:0] Seed   = 16'(STARTING_SEED);

    typedef enum logic [1:0] {StWaitCsHigh, StIdle, StShift, StCommit} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_rise;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bad_word, cmd_err_q;
    logic [15:0] shift_in_q, shift_out_q, resp0_q, resp1_q, frame_q;
    logic [5:0]  chan_q;
    logic [7:0]  regs_q [18];

    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data, rd_data, rom_data;
    logic [15:0] result;
    logic        ch_upd, frame_inc, frame_clr, reg_we;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // CS resets low so a word already in progress is never mistaken for a fresh frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // IDLE is only entered with CS high, so a low level there marks a new frame (even one
    // whose falling edge landed during COMMIT).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bad_word = 1'b0;
        case (state_q)
            StWaitCsHigh: if (cs_s) state_d = StIdle;
            StIdle: begin
                if (!cs_s) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (sclk_rise && cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                if (cs_rise) begin
                    if (cnt_d == 5'd16) begin
                        state_d = StCommit;
                    end else begin
                        state_d  = StIdle;
                        bad_word = 1'b1;
                    end
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StWaitCsHigh;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StWaitCsHigh;
            cnt_q     <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_err_q <= bad_word;
        end
    end

`ifdef RHD_SLAVE_ROM_EN
    always_comb begin
        case (cmd_addr)
            6'd40:   rom_data = 8'h49;
            6'd41:   rom_data = 8'h4E;
            6'd42:   rom_data = 8'h54;
            6'd43:   rom_data = 8'h41;
            6'd44:   rom_data = 8'h4E;
            6'd60:   rom_data = 8'h01;
            6'd61:   rom_data = 8'h01;
            6'd62:   rom_data = 8'(NUM_CHANNELS);
            6'd63:   rom_data = 8'(CHIP_ID);
            default: rom_data = 8'h00;
        endcase
    end
`else
    assign rom_data = 8'h00;
`endif

    always_comb begin
        cmd_addr  = shift_in_q[13:8];
        cmd_data  = shift_in_q[7:0];
        result    = '0;
        ch_upd    = 1'b0;
        frame_inc = 1'b0;
        frame_clr = 1'b0;
        reg_we    = 1'b0;
        rd_data   = 8'h00;
        if (cmd_addr < 6'd18)       rd_data = regs_q[cmd_addr[4:0]];
        else if (cmd_addr >= 6'd40) rd_data = rom_data;
        case (shift_in_q[15:14])
            2'b00: begin
                if ({1'b0, cmd_addr} < NumCh) begin
                    result    = Seed + {10'd0, cmd_addr} + frame_q;
                    ch_upd    = 1'b1;
                    frame_inc = (cmd_addr == LastCh);
                end
            end
            2'b01:   frame_clr = (shift_in_q == 16'h6A00);
            2'b10: begin
                reg_we = (cmd_addr <= 6'd17);
                result = {8'hFF, cmd_data};
            end
            default: result = {8'h00, rd_data};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_in_q  <= '0;
            shift_out_q <= '0;
            resp0_q     <= '0;
            resp1_q     <= '0;
            frame_q     <= '0;
            chan_q      <= '0;
            for (int i = 0; i < 18; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: if (!cs_s) shift_out_q <= resp1_q;
                StShift: begin
                    if (sclk_rise) shift_in_q <= {shift_in_q[14:0], mosi_s};
                    if (sclk_fall) shift_out_q <= {shift_out_q[14:0], 1'b0};
                end
                StCommit: begin
                    resp1_q <= resp0_q;
                    resp0_q <= result;
                    if (ch_upd)    chan_q <= cmd_addr;
                    if (frame_inc) frame_q <= frame_q + 16'd1;
                    if (frame_clr) frame_q <= '0;
                    if (reg_we)    regs_q[cmd_addr[4:0]] <= cmd_data;
                end
                default: ;
            endcase
        end
    end

    assign MISO        = (state_q == StShift) ? shift_out_q[15] : 1'b0;
    assign channel_out = chan_q;
    assign word_done   = (state_q == StCommit);
    assign cmd_error   = cmd_err_q;
    assign frame_cnt   = frame_q;

endmodule
